// File: rtl/seq_detect_scheduler.sv
// Round-robin time-sharing of one serial pattern detector among N_REQ bit-stream requesters.
// Each grant consumes one FRAME_LEN-bit frame and reports the overlapping match count of PAT.
module seq_detect_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PAT = 4'b1011,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 5,
  localparam int unsigned ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] bit_in,
  input  logic [N_REQ-1:0] bit_vld,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic             abort,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned BC_W = $clog2(FRAME_LEN + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_LEN);
  localparam logic [BC_W-1:0]  MIN_BITS = BC_W'(PAT_LEN);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gid;
  logic [PAT_LEN-1:0] shreg;
  logic [BC_W-1:0]    bit_cnt;

  logic               pick_vld;
  logic [ID_W-1:0]    pick;
  logic               acc;
  logic               req_g;
  logic [PAT_LEN-1:0] shreg_nxt;
  logic [BC_W-1:0]    cnt_nxt;
  logic               last;
  logic               hit;

  // Scan upward from ptr+1 so the requester served last has lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    pick_vld = 1'b0;
    pick     = ptr;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      if (!pick_vld && req[(int'(ptr) + i) % int'(N_REQ)]) begin
        pick_vld = 1'b1;
        pick     = ID_W'((int'(ptr) + i) % int'(N_REQ));
      end
    end
  end

  always_comb begin
    acc       = (state == STREAM) && bit_vld[gid];
    req_g     = req[gid];
    shreg_nxt = {shreg[PAT_LEN-2:0], bit_in[gid]};
    cnt_nxt   = bit_cnt + 1'b1;
    last      = acc && (cnt_nxt == LAST_BIT);
    // The bit-count guard stops a cleared register from matching a PAT with leading zeros.
    hit       = acc && (shreg_nxt == PAT) && (cnt_nxt >= MIN_BITS);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= LAST_ID;
      gid       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      match     <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= STREAM;
            gid       <= pick;
            gnt       <= ONE << pick;
            busy      <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
          end
        end
        STREAM: begin
          // A request dropped together with the final bit still completes the frame.
          if (!req_g && !last) begin
            abort   <= 1'b1;
            done_id <= gid;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= gid;
            state   <= IDLE;
          end else if (acc) begin
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
            if (hit) begin
              match <= 1'b1;
              if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end
            if (last) begin
              state   <= REPORT;
              done    <= 1'b1;
              done_id <= gid;
              gnt     <= '0;
              busy    <= 1'b0;
              ptr     <= gid;
            end
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: grants, overlap matching, stalls, abort, reset, saturation.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_seq_detect_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] bit_in;
  logic [N-1:0] bit_vld;

  logic [N-1:0] gnt;
  logic         busy, match, done, abort;
  logic [1:0]   done_id;
  logic [4:0]   match_cnt;

  logic [N-1:0] gnt2;
  logic         busy2, match2, done2, abort2;
  logic [1:0]   done_id2;
  logic [1:0]   match_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .bit_vld(bit_vld),
    .gnt(gnt), .busy(busy), .match(match), .done(done), .abort(abort),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  seq_detect_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .bit_vld(bit_vld),
    .gnt(gnt2), .busy(busy2), .match(match2), .done(done2), .abort(abort2),
    .done_id(done_id2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT idle and req set so the next edge grants 'who'.
  // exp_m marks (MSB = first bit) which accepted bits must raise match.
  task automatic run_frame(input int who, input logic [15:0] bits, input logic [15:0] exp_m,
                           input int stall_at, input int stall_len, input int exp_cnt,
                           input string tag);
    logic [N-1:0] lane;
    lane    = N'(1) << who;
    bit_vld = '0;
    step();
    check({tag, " gnt"}, gnt, lane);
    check({tag, " busy"}, busy, 1);
    check({tag, " cnt clr"}, match_cnt, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bit_vld = ~lane;
          bit_in  = '1;
          step();
          check($sformatf("%s stall%0d match", tag, s), match, 0);
          check($sformatf("%s stall%0d done", tag, s), done, 0);
        end
      end
      bit_vld = '1;
      bit_in  = {N{~bits[15-k]}};
      bit_in[who] = bits[15-k];
      step();
      check($sformatf("%s match b%0d", tag, k + 1), match, exp_m[15-k]);
    end
    bit_vld = '0;
    check({tag, " done"}, done, 1);
    check({tag, " done_id"}, done_id, who);
    check({tag, " final cnt"}, match_cnt, exp_cnt);
    check({tag, " gnt off"}, gnt, 0);
    check({tag, " busy off"}, busy, 0);
    check({tag, " no abort"}, abort, 0);
    step();
    check({tag, " done pulse"}, done, 0);
    check({tag, " cnt hold"}, match_cnt, exp_cnt);
    check({tag, " idle gap"}, gnt, 0);
  endtask

  initial begin
    logic [4:0] ab_bits;
    logic [4:0] ab_m;
    rst = 1'b1; req = '0; bit_in = '0; bit_vld = '0;
    step();
    step();
    check("rst gnt", gnt, 0);
    check("rst busy", busy, 0);
    check("rst match", match, 0);
    check("rst done", done, 0);
    check("rst abort", abort, 0);
    check("rst done_id", done_id, 0);
    check("rst cnt", match_cnt, 0);
    check("rst cnt sat", match_cnt2, 0);
    rst = 1'b0;
    step();
    check("idle no req", gnt, 0);

    // Overlapping matches on bits 4 and 7.
    req = 4'b0001;
    run_frame(0, 16'b1011_0110_0000_0000, 16'b0001_0010_0000_0000, -1, 0, 2, "s1");
    // Same frame with a 3-cycle stall after bit 3.
    run_frame(0, 16'b1011_0110_0000_0000, 16'b0001_0010_0000_0000, 3, 3, 2, "s2");
    // Frame ending 1,0,1 followed by one starting 1,0,0: no match across the boundary.
    run_frame(0, 16'b1011_0000_0000_0101, 16'b0001_0000_0000_0000, -1, 0, 1, "s4a");
    run_frame(0, 16'b1001_0110_0000_0000, 16'b0000_0010_0000_0000, -1, 0, 1, "s4b");

    // Abort of requester 2 after 5 bits; pointer was left at 0.
    req = 4'b1100;
    step();
    check("ab gnt", gnt, 4'b0100);
    ab_bits = 5'b10110;
    ab_m    = 5'b00010;
    for (int k = 0; k < 5; k++) begin
      bit_vld = '1;
      bit_in  = '0;
      bit_in[2] = ab_bits[4-k];
      step();
      check($sformatf("ab match b%0d", k + 1), match, ab_m[4-k]);
    end
    req = 4'b1000;
    bit_in[2] = 1'b1;
    step();
    check("ab abort", abort, 1);
    check("ab no done", done, 0);
    check("ab done_id", done_id, 2);
    check("ab gnt off", gnt, 0);
    check("ab busy off", busy, 0);
    check("ab partial cnt", match_cnt, 1);
    step();
    check("ab pulse", abort, 0);
    check("ab next gnt", gnt, 4'b1000);

    // Reset in the middle of requester 3's frame.
    ab_bits = 5'b01011;
    for (int k = 1; k < 5; k++) begin
      bit_vld = '1;
      bit_in  = '0;
      bit_in[3] = ab_bits[4-k];
      step();
    end
    check("mr match", match, 1);
    check("mr cnt", match_cnt, 1);
    rst = 1'b1;
    step();
    check("mr gnt", gnt, 0);
    check("mr busy", busy, 0);
    check("mr cnt", match_cnt, 0);
    check("mr match clr", match, 0);
    check("mr no done", done, 0);
    check("mr no abort", abort, 0);
    check("mr done_id", done_id, 0);
    rst = 1'b0; req = '0; bit_vld = '0;
    step();
    check("mr idle", gnt, 0);

    // All requesters active: round-robin 0,1,2,3,0.
    req = 4'b1111;
    run_frame(0, 16'h0000, 16'h0000, -1, 0, 0, "rr0");
    run_frame(1, 16'h0000, 16'h0000, -1, 0, 0, "rr1");
    run_frame(2, 16'h0000, 16'h0000, -1, 0, 0, "rr2");
    run_frame(3, 16'h0000, 16'h0000, -1, 0, 0, "rr3");
    run_frame(0, 16'h0000, 16'h0000, -1, 0, 0, "rr0b");

    // Five matches including the last bit; the 2-bit counter saturates at 3.
    run_frame(1, 16'b1011_0110_1101_1011, 16'b0001_0010_0100_1001, -1, 0, 5, "sat");
    check("sat cnt2", match_cnt2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
